// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// opcode/funct fields, ALU control codes and datapath mux selects.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU control codes
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    // ALUOp encodings
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] SRCB_RD2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PCSrc encodings
    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU control decoder: maps ALUOp and the R-type Funct field to an ALU
// operation, flagging Funct codes that the ALU does not implement.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl,
    output logic       bad_funct
);

    // ALU operation select; unknown Funct falls back to add
    always_comb begin
        ALUControl = ALUC_ADD;
        bad_funct  = 1'b0;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUC_ADD;
            ALUOP_SUB: ALUControl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALUC_ADD;
                    FN_SUB:  ALUControl = ALUC_SUB;
                    FN_AND:  ALUControl = ALUC_AND;
                    FN_OR:   ALUControl = ALUC_OR;
                    FN_SLT:  ALUControl = ALUC_SLT;
                    default: begin
                        ALUControl = ALUC_ADD;
                        bad_funct  = 1'b1;
                    end
                endcase
            end
            default: ALUControl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute
// phases and driving datapath strobes; ALU control decoded by alu_decoder.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       Branch,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic [2:0] ALUControl,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_n;
    state_t out_state;
    logic   op_bad;
    logic   bad_funct;

    assign state = state_q;

    // While reset is held the outputs already show FETCH, so no stale
    // mid-instruction write strobe survives into the reset cycle.
    assign out_state = rst ? state_q : FETCH;

    assign op_bad = !(Op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) state_q <= FETCH;
        else      state_q <= state_n;
    end

    // Next-state decode from current state and opcode
    always_comb begin
        state_n = FETCH;
        case (state_q)
            FETCH: state_n = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_n = MEMADR;
                    OP_RTYPE:     state_n = EXECUTE;
                    OP_BEQ:       state_n = BRANCH;
                    OP_ADDI:      state_n = ADDIEXEC;
                    OP_J:         state_n = JUMP;
                    default:      state_n = FETCH;
                endcase
            end
            MEMADR:   state_n = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:    state_n = MEMWB;
            EXECUTE:  state_n = ALUWB;
            ADDIEXEC: state_n = ADDIWB;
            default:  state_n = FETCH;
        endcase
    end

    // Moore outputs per state; unlisted strobes/selects stay 0
    always_comb begin
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        MemWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        Branch   = 1'b0;
        ALUSrcB  = SRCB_RD2;
        PCSrc    = PCSRC_ALURES;
        ALUOp    = ALUOP_ADD;
        case (out_state)
            FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = 1'b1;
                PCWrite = 1'b1;
            end
            DECODE: ALUSrcB = SRCB_IMMSH2;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEMRD: IorD = 1'b1;
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            ADDIWB: RegWrite = 1'b1;
            JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal = ((out_state == DECODE) && op_bad) ||
                     ((out_state == EXECUTE) && bad_funct);

    alu_decoder u_alu_decoder (
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .ALUControl (ALUControl),
        .bad_funct  (bad_funct)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: instruction-path model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] Op = 6'b000000;
    logic [5:0] Funct = 6'b100000;
    logic       IorD, ALUSrcA, IRWrite, PCWrite, MemWrite;
    logic       RegDst, MemtoReg, RegWrite, Branch;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic [2:0] ALUControl;
    logic       illegal;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct      (Funct),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .Branch     (Branch),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUOp      (ALUOp),
        .ALUControl (ALUControl),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       iord, srca, irw, pcw, memw, regdst, m2r, regw, br;
        logic [1:0] srcb, pcsrc, aluop;
    } ctl_t;

    // Control word for each state, straight from the state table
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c = '0;
        case (s)
            FETCH:    begin c.srcb = 2'b01; c.irw = 1; c.pcw = 1; end
            DECODE:   c.srcb = 2'b11;
            MEMADR:   begin c.srca = 1; c.srcb = 2'b10; end
            MEMRD:    c.iord = 1;
            MEMWB:    begin c.m2r = 1; c.regw = 1; end
            MEMWR:    begin c.iord = 1; c.memw = 1; end
            EXECUTE:  begin c.srca = 1; c.aluop = 2'b10; end
            ALUWB:    begin c.regdst = 1; c.regw = 1; end
            BRANCH:   begin c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.br = 1; end
            ADDIEXEC: begin c.srca = 1; c.srcb = 2'b10; end
            ADDIWB:   c.regw = 1;
            JUMP:     begin c.pcsrc = 2'b10; c.pcw = 1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] aluc_of(input logic [1:0] aop, input logic [5:0] fn);
        if (aop == 2'b01) return 3'b110;
        if (aop != 2'b10) return 3'b010;
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic logic op_ok(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Model tracks the remaining states of the current instruction as a queue
    state_t mst = FETCH;
    state_t pending[$];
    bit     chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            mst = FETCH;
            pending.delete();
        end else if (mst == FETCH) begin
            mst = DECODE;
        end else begin
            if (mst == DECODE) begin
                case (Op)
                    6'b100011: pending = '{MEMADR, MEMRD, MEMWB};
                    6'b101011: pending = '{MEMADR, MEMWR};
                    6'b000000: pending = '{EXECUTE, ALUWB};
                    6'b000100: pending = '{BRANCH};
                    6'b001000: pending = '{ADDIEXEC, ADDIWB};
                    6'b000010: pending = '{JUMP};
                    default:   pending.delete();
                endcase
            end
            if (pending.size() > 0) mst = pending.pop_front();
            else                    mst = FETCH;
        end
    end

    // Per-cycle comparison against the model
    state_t vis;
    ctl_t   ec;
    logic   eill;
    always @(negedge clk) begin
        if (chk_en) begin
            vis  = rst ? mst : FETCH;
            ec   = ctl_of(vis);
            eill = rst && ((mst == DECODE && !op_ok(Op)) ||
                           (mst == EXECUTE && !funct_ok(Funct)));
            check("state",      state,      mst);
            check("IorD",       IorD,       ec.iord);
            check("ALUSrcA",    ALUSrcA,    ec.srca);
            check("IRWrite",    IRWrite,    ec.irw);
            check("PCWrite",    PCWrite,    ec.pcw);
            check("MemWrite",   MemWrite,   ec.memw);
            check("RegDst",     RegDst,     ec.regdst);
            check("MemtoReg",   MemtoReg,   ec.m2r);
            check("RegWrite",   RegWrite,   ec.regw);
            check("Branch",     Branch,     ec.br);
            check("ALUSrcB",    ALUSrcB,    ec.srcb);
            check("PCSrc",      PCSrc,      ec.pcsrc);
            check("ALUOp",      ALUOp,      ec.aluop);
            check("ALUControl", ALUControl, aluc_of(ec.aluop, Funct));
            check("illegal",    illegal,    eill);
        end
    end

    // ---------------- directed scenarios ----------------
    // Runs one instruction from FETCH until the DUT returns to FETCH
    task automatic run(input logic [5:0] op, input logic [5:0] fn,
                       output int cyc, output logic ill, output logic [2:0] aluc,
                       output logic [15:0] seen, output logic [1:0] pcs, output logic br);
        Op = op; Funct = fn;
        cyc = 0; ill = illegal; aluc = '0; seen = '0; pcs = PCSrc; br = Branch;
        do begin
            @(posedge clk); #1;
            cyc++;
            seen[state] = 1'b1;
            ill  |= illegal;
            pcs  |= PCSrc;
            br   |= Branch;
            if (state == EXECUTE || state == BRANCH) aluc = ALUControl;
        end while (state != FETCH && cyc < 20);
    endtask

    int          cyc;
    logic        ill, br;
    logic [2:0]  aluc;
    logic [15:0] seen;
    logic [1:0]  pcs;

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b1;
        check("rst_state",   state,    4'd0);
        check("rst_IRWrite", IRWrite,  1'b1);
        check("rst_PCWrite", PCWrite,  1'b1);
        check("rst_ALUSrcB", ALUSrcB,  2'b01);
        check("rst_strobes", {MemWrite, RegWrite, Branch, IorD, illegal}, 5'b0);

        // lw: FETCH DECODE MEMADR MEMRD MEMWB FETCH
        run(6'b100011, 6'b100000, cyc, ill, aluc, seen, pcs, br);
        check("lw_cycles", cyc, 5);
        check("lw_path",   seen[4:2], 3'b111);
        check("lw_ill",    ill, 1'b0);

        // sw
        run(6'b101011, 6'b100000, cyc, ill, aluc, seen, pcs, br);
        check("sw_cycles", cyc, 4);
        check("sw_memwr",  seen[5], 1'b1);

        // R-type slt and or
        run(6'b000000, 6'b101010, cyc, ill, aluc, seen, pcs, br);
        check("slt_cycles", cyc, 4);
        check("slt_aluc",   aluc, 3'b111);
        check("slt_aluwb",  seen[7], 1'b1);
        run(6'b000000, 6'b100101, cyc, ill, aluc, seen, pcs, br);
        check("or_aluc", aluc, 3'b001);
        check("or_ill",  ill, 1'b0);

        // addi
        run(6'b001000, 6'b111111, cyc, ill, aluc, seen, pcs, br);
        check("addi_cycles", cyc, 4);
        check("addi_ill",    ill, 1'b0);

        // beq
        run(6'b000100, 6'b000000, cyc, ill, aluc, seen, pcs, br);
        check("beq_cycles", cyc, 3);
        check("beq_aluc",   aluc, 3'b110);
        check("beq_branch", br, 1'b1);
        check("beq_pcsrc",  pcs, 2'b01);

        // j
        run(6'b000010, 6'b100000, cyc, ill, aluc, seen, pcs, br);
        check("j_cycles", cyc, 3);
        check("j_pcsrc",  pcs, 2'b10);
        check("j_jump",   seen[11], 1'b1);

        // illegal opcode and illegal funct
        run(6'b111111, 6'b100000, cyc, ill, aluc, seen, pcs, br);
        check("badop_cycles", cyc, 2);
        check("badop_ill",    ill, 1'b1);
        run(6'b000000, 6'b000000, cyc, ill, aluc, seen, pcs, br);
        check("badfn_cycles", cyc, 4);
        check("badfn_ill",    ill, 1'b1);
        check("badfn_aluc",   aluc, 3'b010);

        // Reset asserted while in MEMWR
        Op = 6'b101011;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_in_memwr", state, 4'd5);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_state",    state, 4'd0);
        check("mid_memwrite", MemWrite, 1'b0);
        rst = 1'b1;

        // Normal operation resumes after reset release
        run(6'b100011, 6'b100000, cyc, ill, aluc, seen, pcs, br);
        check("post_lw_cycles", cyc, 5);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters; the module SHALL have fixed widths only.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: synchronous, active-low.
REQ-004 Op  input  6  instruction opcode from the datapath (Instr[31:26]).
REQ-005 Funct  input  6  R-type function field (Instr[5:0]).
REQ-006 IorD, ALUSrcA, IRWrite, PCWrite, MemWrite, RegDst, MemtoReg, RegWrite, Branch  output  1 each  datapath strobes and mux selects.
REQ-007 ALUSrcB  output  2  00 = RD2, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
REQ-008 PCSrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-009 ALUOp  output  2  00 = add, 01 = sub, 10 = decode Funct.
REQ-010 ALUControl  output  3  010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported Op or Funct.
REQ-012 state  output  4  current FSM state encoding, for debug and the bench.

Function
REQ-013 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB and JUMP.
REQ-014 Outputs SHALL be Moore, a function of state only; ALUControl and illegal are the exceptions.
REQ-015 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=1, PCWrite=1, and SHALL always go to DECODE.
REQ-016 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- Op 100011 (lw) or 101011 (sw) -> MEMADR.
- Op 000000 -> EXECUTE.
- Op 000100 -> BRANCH.
- Op 001000 -> ADDIEXEC.
- Op 000010 -> JUMP.
- Any other Op -> FETCH, with illegal=1 for that cycle.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00; lw -> MEMRD, sw -> MEMWR.
REQ-018 MEMRD SHALL drive IorD=1 and go to MEMWB.
REQ-019 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1 and go to FETCH.
REQ-020 MEMWR SHALL drive IorD=1, MemWrite=1 and go to FETCH.
REQ-021 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to ALUWB.
REQ-022 ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-023 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 and go to FETCH.
REQ-024 ADDIEXEC SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00 and go to ADDIWB.
REQ-025 ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-026 JUMP SHALL drive PCSrc=10, PCWrite=1 and go to FETCH.
REQ-027 In every state, any strobe or select not listed for that state SHALL be 0.
REQ-028 ALUControl SHALL be combinational from ALUOp and Funct.
- ALUOp 00 -> 010; ALUOp 01 -> 110.
- ALUOp 10: Funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
- ALUOp 10 with any other Funct -> 010, and illegal=1 during EXECUTE.
REQ-029 ALUOp 11 SHALL decode as 010.
REQ-030 Instruction latency in clocks, FETCH through return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-031 The control unit SHALL NOT gate PC enable; the datapath computes PCEn = PCWrite | (Branch & Zero).

Reset
REQ-032 When rst=0 at a rising clk edge, state SHALL become FETCH regardless of the current state, including mid-instruction.
REQ-033 During and after reset, outputs SHALL equal FETCH outputs; illegal SHALL be 0.
REQ-034 No write strobe other than the FETCH values (IRWrite=1, PCWrite=1) SHALL be asserted in the first cycle after reset.
REQ-035 Reset SHALL have priority over every transition.

Structure
REQ-036 Package mips_pkg SHALL hold the state enum, opcode constants, funct constants, ALUControl codes and the ALUSrcB/PCSrc/ALUOp encodings.
REQ-037 ALU control decoding SHALL be a sub-module alu_decoder (ALUOp, Funct -> ALUControl, bad_funct).
REQ-038 The FSM, main decoder and output logic SHALL live in multicycle_control.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Reset: rst=0 for 2 cycles, then 1 -> state=FETCH, IRWrite=1, PCWrite=1, ALUSrcB=01, all other strobes 0.
- lw: Op=100011 -> FETCH, DECODE, MEMADR, MEMRD (IorD=1), MEMWB (MemtoReg=1, RegWrite=1), FETCH; 5 cycles.
- R-type: Op=000000, Funct=101010 -> EXECUTE with ALUControl=111, then ALUWB (RegDst=1, RegWrite=1); Funct=100101 -> ALUControl=001.
- beq and j: Op=000100 -> BRANCH (Branch=1, ALUControl=110, PCSrc=01); Op=000010 -> JUMP (PCWrite=1, PCSrc=10); both back in FETCH after 3 cycles.
- Illegal: Op=111111 -> illegal=1 in DECODE, then FETCH; Op=000000, Funct=000000 -> illegal=1 in EXECUTE.
- Mid-instruction reset: rst=0 while in MEMWR -> FETCH next cycle, MemWrite=0.
